mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Bus initiator for the shared instruction/data memory bus: accepts load/store requests from the microcoded datapath and drives the memory's address, bidirectional data, write-strobe and enable lines. The memory responder only performs big-endian 32-bit word transfers. This block therefore performs byte and halfword stores as read-modify-write sequences, and extracts and extends sub-word loads. It sits between the microsequencer's memory micro-ops and the memory module on the bus.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, bus data width (fixed at 32; byte-lane logic assumes 4 lanes)
- `MEM_LATENCY`, 1, cycles `mem_en` is held with `mem_wrt=0` before read data is captured (≥1)

Ports:
- `clock` in 1 — single clock, all state on rising edge
- `reset` in 1 — reset is asynchronous and active-high
- `req` in 1 — request valid; accepted when `req && ready`
- `wr` in 1 — 1 = store, 0 = load
- `size` in 2 — 00 byte, 01 halfword, 10 word, 11 reserved
- `uns` in 1 — load zero-extends when 1, sign-extends when 0
- `addr` in ADDR_WIDTH — byte address
- `wdata` in 32 — store data (byte in [7:0], half in [15:0])
- `ready` out 1 — high only in IDLE
- `done` out 1 — one-cycle completion pulse
- `err` out 1 — valid with `done`
- `rdata` out 32 — load result, held until next accept
- `mem_addr` out ADDR_WIDTH — bus address, word-aligned for every access
- `mem_data` inout 32 — driven only when `mem_en && mem_wrt`, else Z
- `mem_wrt` out 1 — bus write strobe
- `mem_en` out 1 — bus enable
- `mem_busy` in 1 — responder busy; must be 1 whenever `mem_en` is 1

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `ready=1`. On accept, latch `wr`, `size`, `uns`, `addr`, `wdata`, and set `mem_addr = addr & ~3`.
  - Word store goes to WR.
  - Reserved size goes to RESP with err.
  - Every other request goes to RD.
- RD: `mem_en=1`, `mem_wrt=0` for MEM_LATENCY cycles, counted by a down-counter.
  - On the last cycle's edge, register `mem_data` into the word buffer.
  - Load then goes to RESP. Sub-word store goes to WR.
- WR: one cycle with `mem_en=1` and `mem_wrt=1`. `mem_data` = `wdata` for a word store, or the merged buffer for a sub-word store. The responder commits the write on the closing edge. Next state is RESP.
- RESP: `done=1` for one cycle, then IDLE.
- Lane mapping is big-endian.
  - Byte offset o = `addr[1:0]` selects bits [31-8o : 24-8o].
  - Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
- Loads: the selected lane is right-justified in `rdata`, then sign- or zero-extended per `uns`.
- Sub-word stores: only the selected lane of the buffer is replaced. The other lanes are written back unchanged.
- Bus fault: if `mem_busy=0` in any cycle with `mem_en=1`, latch fault.
  - The sequence still completes.
  - `err=1` at `done`, and `rdata=0` for loads.
- Reset (asynchronous, also mid-operation): state IDLE, `mem_en=0`, `mem_wrt=0`, `mem_data` released, `done=0`, `err=0`, `rdata=0`, `mem_addr=0`, counter 0. A store cut off before its WR edge performs no write.

## Timing
- Cycle 0 is the accept edge.
- Word store: WR in cycle 1; `done` in cycle 2.
- Load: RD in cycles 1..MEM_LATENCY; `done` in cycle MEM_LATENCY+1.
- Sub-word store: RD cycles, then WR, then `done` in cycle MEM_LATENCY+2.
- Reserved size: `done` with `err=1` in cycle 1, with no bus activity.
- Minimum gap between accepts is one cycle after `done`, because `ready` is low in RESP.
- `req` is ignored outside IDLE. Request inputs need not be held after accept.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: misaligned halfword (`addr[0]=1`) or word (`addr[1:0]≠0`) requests go to RESP with `err=1` and `rdata=0`. No bus activity occurs.
- Undefined: low address bits are truncated to natural alignment (half: `addr[0]` ignored; word: `addr[1:0]` ignored). Alignment never raises `err`.

## Structure
- Package `mem_bus_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - the state enum
  - the lane-offset helper constants
- Sub-module `mem_lane_unit` (combinational) holds load extraction/extension and store merge, driven by size, offset and `uns`.
- The FSM, latency counter and tri-state driver live in the top module.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → `rdata=0xDEADBEEF`; the bus shows a single write cycle followed by MEM_LATENCY read cycles.
- Byte store 0x55 to 0x11 over 0xDEADBEEF, then word load from 0x10 → `0xDE55BEEF`; signed byte load from 0x10 → `0xFFFFFFDE`.
- Unsigned halfword load from 0x12 over 0xDE55BEEF → `0x0000BEEF`; signed → `0xFFFFBEEF`.
- With MEM_ALIGN_CHECK_EN, word load from 0x13 → `done` with `err=1` in cycle 1, `mem_en` never high. Without it, the access goes to 0x10 with `err=0`.
- `mem_busy` forced low during RD → `err=1`, `rdata=0`.
- `reset` asserted in RD of a byte store → outputs go to reset values immediately and the memory word is unchanged.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus initiator: access sizes, FSM states
// and big-endian lane-offset helpers.
package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_e;

    localparam int         LANE_BITS   = 8;
    localparam logic [1:0] HALF_HI_OFF = 2'b00;
    localparam logic [1:0] HALF_LO_OFF = 2'b10;

    // Big-endian: byte offset 0 lives in the top lane, so the shift is (3-o)*8.
    function automatic logic [4:0] byteShift(input logic [1:0] off);
        return {~off, 3'b000};
    endfunction

    function automatic logic [4:0] halfShift(input logic [1:0] off);
        return (off[1] == HALF_LO_OFF[1]) ? 5'd0 : 5'd16;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane unit: extracts and extends sub-word loads and merges
// sub-word store data into a previously read word (big-endian lanes).
module mem_lane_unit
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] bword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] mdata_o
);

    logic [4:0]  bSh;
    logic [4:0]  hSh;
    logic [7:0]  lByte;
    logic [15:0] lHalf;

    assign bSh = byteShift(off_i);
    assign hSh = halfShift(off_i);

    always_comb begin
        lByte   = 8'(rword_i >> bSh);
        lHalf   = 16'(rword_i >> hSh);
        ldata_o = rword_i;
        case (size_i)
            SZ_BYTE: ldata_o = uns_i ? {24'b0, lByte} : {{24{lByte[7]}}, lByte};
            SZ_HALF: ldata_o = uns_i ? {16'b0, lHalf} : {{16{lHalf[15]}}, lHalf};
            default: ldata_o = rword_i;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the read word is written back.
    always_comb begin
        mdata_o = wdata_i;
        case (size_i)
            SZ_BYTE: mdata_o = (bword_i & ~(32'h0000_00FF << bSh))
                             | ({24'b0, wdata_i[7:0]} << bSh);
            SZ_HALF: mdata_o = (bword_i & ~(32'h0000_FFFF << hSh))
                             | ({16'b0, wdata_i[15:0]} << hSh);
            default: mdata_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator for word-only memory: sub-word stores via read-modify-write,
// sub-word loads extracted/extended. Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wrt,
    output logic                  mem_en,
    input  logic                  mem_busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  misaligned;
    logic [DATA_WIDTH-1:0] ldata;
    logic [DATA_WIDTH-1:0] mdata;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((size == SZ_HALF) && addr[0])
                     || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    mem_lane_unit u_lane (
        .size_i  (size_q),
        .off_i   (off_q),
        .uns_i   (uns_q),
        .rword_i (mem_data),
        .bword_i (buf_q),
        .wdata_i (wdata_q),
        .ldata_o (ldata),
        .mdata_o (mdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            fault_q    <= fault_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        fault_d    = fault_q;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d       = wr;
                    size_d     = size;
                    uns_d      = uns;
                    off_d      = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                    cnt_d      = CNT_W'(MEM_LATENCY - 1);
                    fault_d    = 1'b0;
                    // Rejected requests reuse the fault flag so err rides out with done.
                    if ((size == SZ_RSVD) || misaligned) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (wr && (size == SZ_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (!mem_busy) fault_d = 1'b1;
                if (cnt_q == '0) begin
                    buf_d = mem_data;
                    if (wr_q) begin
                        state_d = ST_WR;
                    end else begin
                        rdata_d = (fault_q || !mem_busy) ? '0 : ldata;
                        state_d = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR: begin
                if (!mem_busy) fault_d = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = (state_q == ST_RESP);
    assign err      = (state_q == ST_RESP) && fault_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_en   = (state_q == ST_RD) || (state_q == ST_WR);
    assign mem_wrt  = (state_q == ST_WR);
    assign mem_data = (mem_en && mem_wrt) ? mdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed self-checking bench for mem_bus_master with a small word-wide
// memory responder model; follows MEM_ALIGN_CHECK_EN when defined.
module tb_mem_bus_master;

    localparam int LAT = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic        mem_wrt;
    logic        mem_en;
    logic        mem_busy;
    logic        busyKill;

    logic [31:0] mem [0:15];
    int          rdCycles = 0;
    int          wrCycles = 0;
    int          checkCount = 0;
    int          passCount = 0;
    int          failCount = 0;
    int          obsCycle;
    int          obsRd;
    int          obsWr;
    logic        obsErr;
    logic [31:0] obsRdata;

    always #5 clock = ~clock;

    mem_bus_master #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_LATENCY (LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .uns      (uns),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wrt  (mem_wrt),
        .mem_en   (mem_en),
        .mem_busy (mem_busy)
    );

    // Responder model: combinational read data, write committed on the closing edge.
    assign mem_busy = !busyKill;
    assign mem_data = (mem_en && !mem_wrt) ? mem[mem_addr[5:2]] : 32'bz;

    always @(posedge clock)
        if (mem_en && mem_wrt) mem[mem_addr[5:2]] <= mem_data;

    always @(negedge clock)
        if (mem_en) begin
            if (mem_wrt) wrCycles++;
            else         rdCycles++;
        end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] d);
        int  c;
        int  rd0;
        int  wr0;
        bit  seen;
        @(negedge clock);
        req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = d;
        rd0 = rdCycles;
        wr0 = wrCycles;
        @(posedge clock);
        #1;
        req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'hFFFF_FFFF; wdata = '0;
        c = 0;
        seen = 1'b0;
        obsCycle = -1; obsErr = 1'bx; obsRdata = 'x;
        while (!seen && c < 20) begin
            @(negedge clock);
            c++;
            if (done) begin
                seen = 1'b1;
                obsCycle = c;
                obsErr = err;
                obsRdata = rdata;
            end
        end
        if (!seen) checkOutput("done_timeout", 32'(c), 32'(0));
        obsRd = rdCycles - rd0;
        obsWr = wrCycles - wr0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0; busyKill = 1'b0;
        #12;
        checkOutput("rst_ready",   32'(ready),   32'd1);
        checkOutput("rst_done",    32'(done),    32'd0);
        checkOutput("rst_err",     32'(err),     32'd0);
        checkOutput("rst_rdata",   rdata,        32'd0);
        checkOutput("rst_mem_en",  32'(mem_en),  32'd0);
        checkOutput("rst_mem_wrt", 32'(mem_wrt), 32'd0);
        checkOutput("rst_addr",    mem_addr,     32'd0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checkOutput("sw_cycle", 32'(obsCycle), 32'd2);
        checkOutput("sw_err",   32'(obsErr),   32'd0);
        checkOutput("sw_wrcyc", 32'(obsWr),    32'd1);
        checkOutput("sw_rdcyc", 32'(obsRd),    32'd0);
        checkOutput("sw_mem",   mem[4],        32'hDEAD_BEEF);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("lw_rdata", obsRdata,      32'hDEAD_BEEF);
        checkOutput("lw_cycle", 32'(obsCycle), 32'(LAT + 1));
        checkOutput("lw_rdcyc", 32'(obsRd),    32'(LAT));
        checkOutput("lw_wrcyc", 32'(obsWr),    32'd0);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055);
        checkOutput("sb_cycle", 32'(obsCycle), 32'(LAT + 2));
        checkOutput("sb_rdcyc", 32'(obsRd),    32'(LAT));
        checkOutput("sb_wrcyc", 32'(obsWr),    32'd1);
        checkOutput("sb_mem",   mem[4],        32'hDE55_BEEF);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("lw2_rdata", obsRdata, 32'hDE55_BEEF);
        repeat (2) @(negedge clock);
        checkOutput("rdata_hold", rdata, 32'hDE55_BEEF);

        applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        checkOutput("lb_s_0", obsRdata, 32'hFFFF_FFDE);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checkOutput("lb_u_3", obsRdata, 32'h0000_00EF);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        checkOutput("lb_s_1", obsRdata, 32'h0000_0055);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        checkOutput("lh_u_2", obsRdata, 32'h0000_BEEF);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checkOutput("lh_s_2", obsRdata, 32'hFFFF_BEEF);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD_1234);
        checkOutput("sh_mem", mem[4], 32'h1234_BEEF);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        checkOutput("lh_s_0", obsRdata, 32'h0000_1234);

        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checkOutput("rsv_cycle", 32'(obsCycle),   32'd1);
        checkOutput("rsv_err",   32'(obsErr),     32'd1);
        checkOutput("rsv_bus",   32'(obsRd + obsWr), 32'd0);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("mis_cycle", 32'(obsCycle),      32'd1);
        checkOutput("mis_err",   32'(obsErr),        32'd1);
        checkOutput("mis_rdata", obsRdata,           32'd0);
        checkOutput("mis_bus",   32'(obsRd + obsWr), 32'd0);
`else
        checkOutput("mis_cycle", 32'(obsCycle), 32'(LAT + 1));
        checkOutput("mis_err",   32'(obsErr),   32'd0);
        checkOutput("mis_rdata", obsRdata,      32'h1234_BEEF);
`endif

        busyKill = 1'b1;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        busyKill = 1'b0;
        checkOutput("busy_err",   32'(obsErr), 32'd1);
        checkOutput("busy_rdata", obsRdata,    32'd0);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);
        checkOutput("pre_mem5", mem[5], 32'hCAFE_F00D);

        @(negedge clock);
        req = 1'b1; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h15; wdata = 32'hAA;
        @(posedge clock);
        #1;
        req = 1'b0;
        @(negedge clock);
        checkOutput("mid_in_rd", 32'(mem_en), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_mem_en",  32'(mem_en),  32'd0);
        checkOutput("mid_mem_wrt", 32'(mem_wrt), 32'd0);
        checkOutput("mid_ready",   32'(ready),   32'd1);
        checkOutput("mid_rdata",   rdata,        32'd0);
        checkOutput("mid_addr",    mem_addr,     32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("mid_mem5", mem[5], 32'hCAFE_F00D);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        checkOutput("post_rst_lw", obsRdata, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
